// File: rtl/fpadd_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fpadd_pipe
// Brief   : 3-stage FP add/sub, FTZ + RNE, valid/ready; FPADD_FLAGS_EN adds flags.
// Revision: 1.0
// ============================================================================
module fpadd_pipe #(
    parameter int EW = 5,
    parameter int MW = 10
) (
    input  logic           CLK,
    input  logic           RESETn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] A,
    input  logic [EW+MW:0] B,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef FPADD_FLAGS_EN
    output logic [2:0]     flags,
`endif
    output logic [EW+MW:0] sum
);

    localparam int c_W  = 1 + EW + MW;
    localparam int c_MX = MW + 4;
    localparam int c_XW = EW + 8;
    localparam logic [EW-1:0]  c_EMAX = {EW{1'b1}};
    localparam logic [c_W-1:0] c_QNAN = {1'b0, {EW{1'b1}}, {(MW-1){1'b0}}, 1'b1};

    logic           out_valid_q;
    logic [c_W-1:0] sum_q, sum_d;
    logic           w_advance;

    assign w_advance = ~out_valid_q | out_ready;

    // ---------------- stage 1: decode, specials, swap, align
    logic          w_sa, w_sb, w_ss, w_swap;
    logic [EW-1:0] w_ea, w_eb, w_es;
    logic [MW-1:0] w_fa, w_fb, w_fl, w_fs;
    logic          w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic [c_XW-1:0] w_d;
    logic [c_MX-1:0] w_ext, w_mask;

    logic            s1_valid_q, s1_spec_q, s1_spec_d, s1_sign_q, s1_sign_d, s1_op_q, s1_op_d;
    logic [c_W-1:0]  s1_res_q, s1_res_d;
    logic [EW-1:0]   s1_exp_q, s1_exp_d;
    logic [c_MX-1:0] s1_ml_q, s1_ml_d, s1_ms_q, s1_ms_d;
`ifdef FPADD_FLAGS_EN
    logic            s1_inv_q, s1_inv_d, s2_inv_q;
    logic [2:0]      flags_q, flags_d;
`endif

    assign w_sa = A[c_W-1];
    assign w_sb = B[c_W-1] ^ sub;
    assign w_ea = A[c_W-2:MW];
    assign w_eb = B[c_W-2:MW];
    assign w_fa = A[MW-1:0];
    assign w_fb = B[MW-1:0];
    assign w_nan_a  = (w_ea == c_EMAX) && (w_fa != '0);
    assign w_nan_b  = (w_eb == c_EMAX) && (w_fb != '0);
    assign w_inf_a  = (w_ea == c_EMAX) && (w_fa == '0);
    assign w_inf_b  = (w_eb == c_EMAX) && (w_fb == '0);
    assign w_zero_a = (w_ea == '0);
    assign w_zero_b = (w_eb == '0);

    always_comb begin
        w_swap    = B[c_W-2:0] > A[c_W-2:0];
        s1_sign_d = w_swap ? w_sb : w_sa;
        w_ss      = w_swap ? w_sa : w_sb;
        s1_exp_d  = w_swap ? w_eb : w_ea;
        w_es      = w_swap ? w_ea : w_eb;
        w_fl      = w_swap ? w_fb : w_fa;
        w_fs      = w_swap ? w_fa : w_fb;
        s1_op_d   = s1_sign_d ^ w_ss;
        s1_ml_d   = {1'b1, w_fl, 3'b000};
        w_ext     = {1'b1, w_fs, 3'b000};
        w_d       = c_XW'(s1_exp_d) - c_XW'(w_es);
        w_mask    = ~({c_MX{1'b1}} << w_d);
        // Bits shifted past the round position collapse into the sticky LSB
        if (w_d >= c_XW'(MW + 3))
            s1_ms_d = c_MX'(1'b1);
        else
            s1_ms_d = (w_ext >> w_d) | c_MX'(|(w_ext & w_mask));
    end

    always_comb begin
        s1_spec_d = 1'b1;
        s1_res_d  = c_QNAN;
`ifdef FPADD_FLAGS_EN
        s1_inv_d  = 1'b0;
`endif
        if (w_nan_a | w_nan_b) begin
            s1_res_d = c_QNAN;
        end else if (w_inf_a & w_inf_b & (w_sa ^ w_sb)) begin
            s1_res_d = c_QNAN;
`ifdef FPADD_FLAGS_EN
            s1_inv_d = 1'b1;
`endif
        end else if (w_inf_a) begin
            s1_res_d = {w_sa, c_EMAX, {MW{1'b0}}};
        end else if (w_inf_b) begin
            s1_res_d = {w_sb, c_EMAX, {MW{1'b0}}};
        end else if (w_zero_a & w_zero_b) begin
            s1_res_d = {w_sa & w_sb, {(EW+MW){1'b0}}};
        end else if (w_zero_a) begin
            s1_res_d = {w_sb, B[c_W-2:0]};
        end else if (w_zero_b) begin
            s1_res_d = A;
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    // ---------------- stage 2: magnitude add/subtract (larger operand first, never negative)
    logic            s2_valid_q, s2_spec_q, s2_sign_q;
    logic [c_W-1:0]  s2_res_q;
    logic [EW-1:0]   s2_exp_q;
    logic [c_MX:0]   s2_mag_q, s2_mag_d;

    assign s2_mag_d = s1_op_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                              : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});

    // ---------------- stage 3: normalise, round, pack
    logic [c_XW-1:0] w_lz, w_e;
    logic [c_MX-1:0] w_m;
    logic [MW:0]     w_fr;
    logic            w_up, w_uf, w_of;
`ifdef FPADD_FLAGS_EN
    logic            w_inx;
`endif

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < c_MX; i++)
            if (s2_mag_q[i]) w_lz = c_XW'(c_MX - 1 - i);
        if (s2_mag_q[c_MX]) begin
            w_m = {s2_mag_q[c_MX:2], |s2_mag_q[1:0]};
            w_e = c_XW'(s2_exp_q) + c_XW'(1);
        end else begin
            w_m = s2_mag_q[c_MX-1:0] << w_lz;
            w_e = c_XW'(s2_exp_q) - w_lz;
        end
        w_up = w_m[2] & (w_m[3] | w_m[1] | w_m[0]);
        w_fr = {1'b0, w_m[c_MX-2:3]} + {{MW{1'b0}}, w_up};
        if (w_fr[MW]) w_e = w_e + c_XW'(1);
        w_uf  = w_e[c_XW-1] | (w_e == '0);
        w_of  = ~w_e[c_XW-1] & (w_e >= c_XW'(c_EMAX));
        sum_d = {s2_sign_q, w_e[EW-1:0], w_fr[MW-1:0]};
`ifdef FPADD_FLAGS_EN
        w_inx   = |w_m[2:0];
        flags_d = {2'b00, w_inx};
`endif
        // Hidden bit clear after normalisation means exact cancellation
        if (s2_spec_q) begin
            sum_d = s2_res_q;
`ifdef FPADD_FLAGS_EN
            flags_d = {s2_inv_q, 2'b00};
`endif
        end else if (!w_m[c_MX-1]) begin
            sum_d = '0;
`ifdef FPADD_FLAGS_EN
            flags_d = 3'b000;
`endif
        end else if (w_of) begin
            sum_d = {s2_sign_q, c_EMAX, {MW{1'b0}}};
`ifdef FPADD_FLAGS_EN
            flags_d = 3'b011;
`endif
        end else if (w_uf) begin
            sum_d = '0;
        end
    end

    // ---------------- registers
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
`ifdef FPADD_FLAGS_EN
            flags_q     <= 3'b000;
`endif
        end else if (w_advance) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            sum_q       <= sum_d;
`ifdef FPADD_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (w_advance) begin
            s1_spec_q <= s1_spec_d;
            s1_res_q  <= s1_res_d;
            s1_sign_q <= s1_sign_d;
            s1_op_q   <= s1_op_d;
            s1_exp_q  <= s1_exp_d;
            s1_ml_q   <= s1_ml_d;
            s1_ms_q   <= s1_ms_d;
            s2_spec_q <= s1_spec_q;
            s2_res_q  <= s1_res_q;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
            s2_mag_q  <= s2_mag_d;
`ifdef FPADD_FLAGS_EN
            s1_inv_q  <= s1_inv_d;
            s2_inv_q  <= s1_inv_q;
`endif
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
`ifdef FPADD_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpadd_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpadd_pipe
// Brief   : Directed self-checking bench for fpadd_pipe at EW=5, MW=10 (fp16).
// Revision: 1.0
// ============================================================================
module tb_fpadd_pipe;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] sum;
`ifdef FPADD_FLAGS_EN
    logic [2:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    always #5 CLK = ~CLK;

    fpadd_pipe #(.EW(5), .MW(10)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FPADD_FLAGS_EN
        .flags     (flags),
`endif
        .sum       (sum)
    );

    function automatic logic [2:0] get_flags();
`ifdef FPADD_FLAGS_EN
        return flags;
`else
        return 3'b000;
`endif
    endfunction

    // Issue one op (called just after a rising edge with in_ready=1) and wait for its result
    task automatic drive_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                             output logic [15:0] r, output logic [2:0] f, output int lat);
        A = a; B = b; sub = s; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        r = sum;
        f = get_flags();
    endtask

    task automatic run_table(input string tag, input vec_t v[], input int n);
    endtask

    task automatic test_reset();
        RESETn = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid out_valid=%b expected 0", out_valid); end
        n_checks++;
        if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum sum=%h expected 0000", sum); end
`ifdef FPADD_FLAGS_EN
        n_checks++;
        if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags flags=%b expected 000", flags); end
`endif
        RESETn = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready in_ready=%b expected 1", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        vec_t v [0:3];
        logic [15:0] r; logic [2:0] f; int lat;
        v = '{{16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000},
              {16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000},
              {16'h4000, 16'h3C00, 1'b1, 16'h3C00, 3'b000},
              {16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000}};
        for (int i = 0; i < 4; i++) begin
            drive_one(v[i].a, v[i].b, v[i].s, r, f, lat);
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL basic_latency[%0d] latency=%0d expected 3", i, lat); end
            n_checks++;
            if (r !== v[i].r) begin n_fail++; $display("FAIL basic_sum[%0d] sum=%h expected %h", i, r, v[i].r); end
`ifdef FPADD_FLAGS_EN
            n_checks++;
            if (f !== v[i].f) begin n_fail++; $display("FAIL basic_flags[%0d] flags=%b expected %b", i, f, v[i].f); end
`endif
        end
    endtask

    task automatic test_rounding();
        vec_t v [0:7];
        logic [15:0] r; logic [2:0] f; int lat;
        v = '{{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001},   // tie, even stays
              {16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001},   // tie, odd rounds up
              {16'h3C00, 16'h1001, 1'b0, 16'h3C01, 3'b001},   // above half
              {16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000},   // exact cancellation
              {16'h3C00, 16'h0400, 1'b0, 16'h3C00, 3'b001},   // sticky-only shift
              {16'h3C00, 16'h0400, 1'b1, 16'h3C00, 3'b001},   // round carry renormalises
              {16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b000},   // below min normal
              {16'h8401, 16'h8400, 1'b1, 16'h0000, 3'b000}};  // negative tiny -> +0
        for (int i = 0; i < 8; i++) begin
            drive_one(v[i].a, v[i].b, v[i].s, r, f, lat);
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL round_latency[%0d] latency=%0d expected 3", i, lat); end
            n_checks++;
            if (r !== v[i].r) begin n_fail++; $display("FAIL round_sum[%0d] sum=%h expected %h", i, r, v[i].r); end
`ifdef FPADD_FLAGS_EN
            n_checks++;
            if (f !== v[i].f) begin n_fail++; $display("FAIL round_flags[%0d] flags=%b expected %b", i, f, v[i].f); end
`endif
        end
    endtask

    task automatic test_specials();
        vec_t v [0:15];
        logic [15:0] r; logic [2:0] f; int lat;
        v = '{{16'h7C00, 16'hFC00, 1'b0, 16'h7C01, 3'b100},
              {16'h7C00, 16'h7C00, 1'b1, 16'h7C01, 3'b100},
              {16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011},
              {16'hFBFF, 16'h7BFF, 1'b1, 16'hFC00, 3'b011},
              {16'h7E00, 16'h3C00, 1'b0, 16'h7C01, 3'b000},
              {16'h3C00, 16'h7E00, 1'b1, 16'h7C01, 3'b000},
              {16'h7C01, 16'hFC00, 1'b0, 16'h7C01, 3'b000},
              {16'h7E00, 16'h0000, 1'b0, 16'h7C01, 3'b000},
              {16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000},
              {16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000},
              {16'h0001, 16'h3C00, 1'b0, 16'h3C00, 3'b000},
              {16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000},
              {16'h8000, 16'h0000, 1'b0, 16'h0000, 3'b000},
              {16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b000},
              {16'h0000, 16'h3C00, 1'b1, 16'hBC00, 3'b000},
              {16'h3C00, 16'h0000, 1'b1, 16'h3C00, 3'b000}};
        for (int i = 0; i < 16; i++) begin
            drive_one(v[i].a, v[i].b, v[i].s, r, f, lat);
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL special_latency[%0d] latency=%0d expected 3", i, lat); end
            n_checks++;
            if (r !== v[i].r) begin n_fail++; $display("FAIL special_sum[%0d] sum=%h expected %h", i, r, v[i].r); end
`ifdef FPADD_FLAGS_EN
            n_checks++;
            if (f !== v[i].f) begin n_fail++; $display("FAIL special_flags[%0d] flags=%b expected %b", i, f, v[i].f); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_in [0:5];
        logic [15:0] exp_r [0:5];
        a_in  = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4800, 16'h3C00};
        exp_r = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4700, 16'h0000};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (cyc < 6);
            A = (cyc < 6) ? a_in[cyc] : 16'h0000;
            B = 16'h3C00; sub = 1'b1;
            #1;
            if (cyc < 6) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cycle %0d in_ready=%b expected 1", cyc, in_ready); end
            end
            if (cyc >= 3 && cyc < 9) begin
                n_checks++;
                if (out_valid !== 1'b1 || sum !== exp_r[cyc-3])
                    begin n_fail++; $display("FAIL b2b_out cycle %0d valid=%b sum=%h expected valid=1 sum=%h", cyc, out_valid, sum, exp_r[cyc-3]); end
            end else if (cyc == 9) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain out_valid=%b expected 0", out_valid); end
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0; sub = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] b_in [0:7];
        logic [15:0] exp_r [0:7];
        int in_idx = 0;
        int out_idx = 0;
        logic held_v = 1'b0;
        logic [15:0] held_sum = '0;
        logic acc;
        b_in  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
        exp_r = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
        for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (in_idx < 8);
            A = 16'h3C00;
            B = (in_idx < 8) ? b_in[in_idx] : 16'h0000;
            sub = 1'b0;
            #1;
            if (held_v) begin
                n_checks++;
                if (out_valid !== 1'b1 || sum !== held_sum)
                    begin n_fail++; $display("FAIL bp_hold cycle %0d valid=%b sum=%h expected valid=1 sum=%h", cyc, out_valid, sum, held_sum); end
            end
            if (!out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d in_ready=%b expected 0", cyc, in_ready); end
            end
            held_v   = out_valid && !out_ready;
            held_sum = sum;
            acc      = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_checks++;
                if (sum !== exp_r[out_idx]) begin n_fail++; $display("FAIL bp_order[%0d] sum=%h expected %h", out_idx, sum, exp_r[out_idx]); end
                out_idx++;
            end
            @(posedge CLK); #1;
            if (acc) in_idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (out_idx != 8) begin n_fail++; $display("FAIL bp_count delivered=%0d expected 8", out_idx); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] r; logic [2:0] f; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = 16'h3C00; B = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        RESETn = 1'b0;
        @(posedge CLK); #1;
        RESETn = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid out_valid=%b expected 0", out_valid); end
        n_checks++;
        if (sum !== 16'h0000) begin n_fail++; $display("FAIL midreset_sum sum=%h expected 0000", sum); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready in_ready=%b expected 1", in_ready); end
        drive_one(16'h3C00, 16'h4000, 1'b0, r, f, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL midreset_latency latency=%0d expected 3", lat); end
        n_checks++;
        if (r !== 16'h4200) begin n_fail++; $display("FAIL midreset_result sum=%h expected 4200", r); end
        @(posedge CLK); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_ghost out_valid=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
